// File: rtl/maze_pkg.sv
// Shared types and VGA/map geometry for the maze tile RAM arbiter.
package maze_pkg;

    typedef logic [3:0] tile_t;

    localparam int unsigned MAP_COLS = 16;
    localparam int unsigned MAP_ROWS = 15;
    localparam int unsigned TILE_PX  = 32;
    localparam int unsigned H_PIXELS = 640;
    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_LINES  = 480;
    localparam int unsigned V_TOTAL  = 521;

    // Who issued the RAM access currently in flight.
    typedef enum logic [1:0] {
        OwnNone   = 2'd0,
        OwnDisp   = 2'd1,
        OwnClient = 2'd2
    } owner_e;

endpackage

// File: rtl/maze_fetch_sched.sv
// Display tile-fetch scheduler: decides in which cycles the display owns the RAM
// and which map address it fetches, three pixels ahead of the tile boundary.
module maze_fetch_sched
    import maze_pkg::*;
(
    input  logic [9:0] col,
    input  logic [9:0] row,
    output logic       trig,
    output logic [7:0] addr
);

    localparam logic [9:0] VLines       = 10'(V_LINES);
    localparam logic [9:0] VLast        = 10'(V_TOTAL - 1);
    localparam logic [9:0] HFetch       = 10'(H_TOTAL - 3);
    localparam logic [9:0] LastFetchCol = 10'((MAP_COLS - 1) * TILE_PX);
    localparam logic [4:0] FetchPhase   = 5'(TILE_PX - 3);

    logic [9:0] next_line;
    logic [3:0] next_tile_col;
    logic       trig_a;
    logic       trig_b;

    always_comb begin
        next_line     = (row == VLast) ? 10'd0 : row + 10'd1;
        next_tile_col = col[8:5] + 4'd1;
        // In-line fetch of the next tile; the last tile of a line has no successor.
        trig_a        = (row < VLines) && (col < LastFetchCol) && (col[4:0] == FetchPhase);
        // End-of-line fetch of tile 0 for the following visible line.
        trig_b        = (col == HFetch) && (next_line < VLines);
        trig          = trig_a | trig_b;
        addr          = trig_a ? {row[8:5], next_tile_col} : {next_line[8:5], 4'd0};
    end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Shares one single-port maze RAM between the pixel display fetch (always wins)
// and a game-logic client port; responses are steered by a 2-stage owner pipeline.
module maze_mem_arbiter
    import maze_pkg::*;
#(
    parameter bit WR_VBLANK_ONLY = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_col,
    input  logic [9:0] i_row,
    input  logic       i_req,
    input  logic       i_we,
    input  logic [7:0] i_addr,
    input  logic [3:0] i_wdata,
    output logic       o_gnt,
    output logic       o_rvalid,
    output logic [3:0] o_rdata,
    output logic       o_mem_en,
    output logic       o_mem_we,
    output logic [7:0] o_mem_addr,
    output logic [3:0] o_mem_wdata,
    input  logic [3:0] i_mem_rdata,
    output logic [3:0] o_tile,
    output logic       o_tile_vld
);

    localparam logic [9:0] VLines   = 10'(V_LINES);
    localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
    localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);
    localparam logic [9:0] DispCols = 10'(MAP_COLS * TILE_PX);

    logic       sched_trig;
    logic [7:0] sched_addr;
    logic       wr_ok;
    logic       gnt;
    logic [9:0] nxt_col;
    logic [9:0] nxt_row;
    logic       nxt_vis;
    owner_e     own1_q;
    owner_e     own2_q;

    maze_fetch_sched u_sched (
        .col  (i_col),
        .row  (i_row),
        .trig (sched_trig),
        .addr (sched_addr)
    );

    always_comb begin
        wr_ok = !i_we || !WR_VBLANK_ONLY || (i_row >= VLines);
        gnt   = !rst && i_req && !sched_trig && wr_ok;
        if (i_col == HLast) begin
            nxt_col = 10'd0;
            nxt_row = (i_row == VLast) ? 10'd0 : i_row + 10'd1;
        end else begin
            nxt_col = i_col + 10'd1;
            nxt_row = i_row;
        end
        // Valid flag is computed for the next pixel so it lines up with o_tile.
        nxt_vis = (nxt_col < DispCols) && (nxt_row < VLines);
    end

    assign o_gnt    = gnt;
    assign o_rvalid = !rst && (own2_q == OwnClient);
    assign o_rdata  = o_rvalid ? i_mem_rdata : 4'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 8'd0;
            o_mem_wdata <= 4'd0;
            own1_q      <= OwnNone;
            own2_q      <= OwnNone;
            o_tile      <= 4'd0;
            o_tile_vld  <= 1'b0;
        end else begin
            o_mem_en    <= sched_trig | gnt;
            o_mem_we    <= gnt & i_we;
            o_mem_addr  <= sched_trig ? sched_addr : (gnt ? i_addr : 8'd0);
            o_mem_wdata <= (gnt && i_we) ? i_wdata : 4'd0;
            own1_q      <= sched_trig ? OwnDisp : (gnt ? OwnClient : OwnNone);
            own2_q      <= own1_q;
            if (own2_q == OwnDisp) begin
                o_tile <= i_mem_rdata;
            end
            o_tile_vld  <= nxt_vis;
        end
    end

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Directed bench for maze_mem_arbiter: grant/port vector table plus timed sequences.
module tb_maze_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [9:0] i_col, i_row;
    logic       req, we;
    logic [7:0] addr;
    logic [3:0] wdata;

    logic       gnt0, rvalid0, en0, mwe0, tvld0;
    logic [3:0] rdata0, mwd0, mrd0, tile0;
    logic [7:0] maddr0;
    logic       gnt1, rvalid1, en1, mwe1, tvld1;
    logic [3:0] rdata1, mwd1, mrd1, tile1;
    logic [7:0] maddr1;

    logic [3:0] ram0 [256];
    logic [3:0] ram1 [256];

    int n_chk  = 0;
    int n_fail = 0;

    always #20 clk = ~clk;

    maze_mem_arbiter #(.WR_VBLANK_ONLY(1'b0)) u0 (
        .clk(clk), .rst(rst), .i_col(i_col), .i_row(i_row),
        .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_gnt(gnt0), .o_rvalid(rvalid0), .o_rdata(rdata0),
        .o_mem_en(en0), .o_mem_we(mwe0), .o_mem_addr(maddr0), .o_mem_wdata(mwd0),
        .i_mem_rdata(mrd0), .o_tile(tile0), .o_tile_vld(tvld0)
    );

    maze_mem_arbiter #(.WR_VBLANK_ONLY(1'b1)) u1 (
        .clk(clk), .rst(rst), .i_col(i_col), .i_row(i_row),
        .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_gnt(gnt1), .o_rvalid(rvalid1), .o_rdata(rdata1),
        .o_mem_en(en1), .o_mem_we(mwe1), .o_mem_addr(maddr1), .o_mem_wdata(mwd1),
        .i_mem_rdata(mrd1), .o_tile(tile1), .o_tile_vld(tvld1)
    );

    // Single-port RAMs with 1-cycle synchronous read, preloaded with addr[3:0].
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) begin
                ram0[i] <= 4'(i);
                ram1[i] <= 4'(i);
            end
        end else begin
            if (en0) begin
                if (mwe0) ram0[maddr0] <= mwd0;
                else      mrd0 <= ram0[maddr0];
            end
            if (en1) begin
                if (mwe1) ram1[maddr1] <= mwd1;
                else      mrd1 <= ram1[maddr1];
            end
        end
    end

    typedef struct {
        logic [9:0] row;
        logic [9:0] col;
        logic       req;
        logic       we;
        logic [7:0] addr;
        logic [3:0] wdata;
        logic       gnt0;
        logic       gnt1;
        logic       en;
        logic       mwe;
        logic [7:0] maddr;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (row %0d col %0d): got 0x%0h, expected 0x%0h",
                     name, i_row, i_col, act, exp);
        end
    endtask

    task automatic set_pos(input logic [9:0] r, input logic [9:0] c);
        i_row = r;
        i_col = c;
    endtask

    // Advance one pixel; inputs change 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (i_col == 10'd799) begin
            i_col = 10'd0;
            i_row = (i_row == 10'd520) ? 10'd0 : i_row + 10'd1;
        end else begin
            i_col = i_col + 10'd1;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},      32'(gnt0),    0);
        chk({tag, "_rvalid"},   32'(rvalid0), 0);
        chk({tag, "_rdata"},    32'(rdata0),  0);
        chk({tag, "_mem_en"},   32'(en0),     0);
        chk({tag, "_mem_we"},   32'(mwe0),    0);
        chk({tag, "_mem_addr"}, 32'(maddr0),  0);
        chk({tag, "_mem_wd"},   32'(mwd0),    0);
        chk({tag, "_tile"},     32'(tile0),   0);
        chk({tag, "_tile_vld"}, 32'(tvld0),   0);
    endtask

    initial begin
        vecs[0]  = '{10'd10,  10'd29,  1'b1, 1'b0, 8'h25, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01};
        vecs[1]  = '{10'd10,  10'd30,  1'b1, 1'b0, 8'h25, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h25};
        vecs[2]  = '{10'd100, 10'd200, 1'b1, 1'b1, 8'h33, 4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33};
        vecs[3]  = '{10'd100, 10'd797, 1'b1, 1'b0, 8'h11, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h30};
        vecs[4]  = '{10'd479, 10'd797, 1'b1, 1'b0, 8'h11, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11};
        vecs[5]  = '{10'd520, 10'd797, 1'b1, 1'b0, 8'h12, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[6]  = '{10'd200, 10'd477, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h6F};
        vecs[7]  = '{10'd200, 10'd509, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{10'd480, 10'd29,  1'b1, 1'b1, 8'h44, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44};
        vecs[9]  = '{10'd300, 10'd61,  1'b1, 1'b0, 8'h20, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h92};
        vecs[10] = '{10'd479, 10'd10,  1'b1, 1'b1, 8'h50, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 8'h50};

        rst = 1'b1; load = 1'b1; req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 4'h0;
        set_pos(10'd0, 10'd0);
        @(posedge clk); #1;
        load = 1'b0;
        req  = 1'b1;
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        req = 1'b0;

        // Grant decisions and the following-cycle RAM port.
        for (int v = 0; v < 11; v++) begin
            set_pos(vecs[v].row, vecs[v].col);
            req = vecs[v].req; we = vecs[v].we; addr = vecs[v].addr; wdata = vecs[v].wdata;
            @(negedge clk);
            chk("vec_gnt0", 32'(gnt0), 32'(vecs[v].gnt0));
            chk("vec_gnt1", 32'(gnt1), 32'(vecs[v].gnt1));
            step();
            chk("vec_mem_en",   32'(en0),    32'(vecs[v].en));
            chk("vec_mem_we",   32'(mwe0),   32'(vecs[v].mwe));
            chk("vec_mem_addr", 32'(maddr0), 32'(vecs[v].maddr));
        end
        req = 1'b0; we = 1'b0;

        // Full line of display at row 40.
        set_pos(10'd39, 10'd790);
        while (!(i_row == 10'd41 && i_col == 10'd0)) begin
            @(negedge clk);
            if (i_row == 10'd40) begin
                if (i_col < 10'd512) begin
                    chk("row40_tile", 32'(tile0), 32'(i_col >> 5));
                    chk("row40_vld",  32'(tvld0), 1);
                end else begin
                    chk("row40_vld_off", 32'(tvld0), 0);
                end
            end
            step();
        end

        // Read collides with a trigger at col 61.
        set_pos(10'd10, 10'd61);
        req = 1'b1; we = 1'b0; addr = 8'h25;
        @(negedge clk); chk("coll_gnt_t", 32'(gnt0), 0);
        step();
        @(negedge clk); chk("coll_gnt_t1", 32'(gnt0), 1);
        step();
        req = 1'b0;
        @(negedge clk);
        chk("coll_rvalid_63", 32'(rvalid0), 0);
        chk("coll_port_addr", 32'(maddr0), 'h25);
        step();
        @(negedge clk);
        chk("coll_rvalid_64", 32'(rvalid0), 1);
        chk("coll_rdata_64",  32'(rdata0),  5);
        chk("coll_tile_64",   32'(tile0),   2);
        step();
        @(negedge clk);
        chk("coll_rvalid_65", 32'(rvalid0), 0);
        chk("coll_tile_65",   32'(tile0),   2);
        step();

        // Back-to-back reads in vertical blanking.
        set_pos(10'd490, 10'd100);
        for (int i = 0; i < 10; i++) begin
            req  = (i < 8);
            addr = 8'(8'h70 + i);
            @(negedge clk);
            if (i < 8) chk("b2b_gnt", 32'(gnt0), 1);
            if (i < 2) begin
                chk("b2b_rvalid_lead", 32'(rvalid0), 0);
            end else begin
                chk("b2b_rvalid", 32'(rvalid0), 1);
                chk("b2b_rdata",  32'(rdata0),  32'(i - 2));
            end
            step();
        end
        req = 1'b0;
        @(negedge clk); chk("b2b_rvalid_end", 32'(rvalid0), 0);
        step();

        // Write 9 to map cell 0, then check the frame-start fetch from row 520.
        set_pos(10'd490, 10'd200);
        req = 1'b1; we = 1'b1; addr = 8'h00; wdata = 4'h9;
        @(negedge clk);
        chk("wr0_gnt0", 32'(gnt0), 1);
        chk("wr0_gnt1", 32'(gnt1), 1);
        step();
        req = 1'b0; we = 1'b0;
        set_pos(10'd520, 10'd790);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (i_row == 10'd520 && i_col == 10'd798) begin
                chk("wrap_mem_en",   32'(en0),    1);
                chk("wrap_mem_we",   32'(mwe0),   0);
                chk("wrap_mem_addr", 32'(maddr0), 0);
            end
            if (i_row == 10'd520 && i_col == 10'd799) chk("wrap_vld_off", 32'(tvld0), 0);
            if (i_row == 10'd0 && i_col == 10'd0) begin
                chk("wrap_tile", 32'(tile0), 9);
                chk("wrap_vld",  32'(tvld0), 1);
            end
            step();
        end

        // Writes held off until vertical blanking on the write-protected instance.
        set_pos(10'd100, 10'd200);
        req = 1'b1; we = 1'b1; addr = 8'h21; wdata = 4'hC;
        @(negedge clk); chk("vb_gnt_active", 32'(gnt1), 0);
        step();
        @(negedge clk);
        chk("vb_gnt_active2", 32'(gnt1), 0);
        chk("vb_no_port",     32'(en1),  0);
        set_pos(10'd479, 10'd799);
        @(negedge clk); chk("vb_gnt_479", 32'(gnt1), 0);
        step();
        @(negedge clk); chk("vb_gnt_480", 32'(gnt1), 1);
        step();
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        chk("vb_mem_en",   32'(en1),    1);
        chk("vb_mem_we",   32'(mwe1),   1);
        chk("vb_mem_addr", 32'(maddr1), 'h21);
        chk("vb_mem_wd",   32'(mwd1),   'hC);
        set_pos(10'd70, 10'd20);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (i_col >= 10'd32) chk("vb_tile_next_frame", 32'(tile1), 'hC);
            step();
        end

        // Reset during a granted read's T+1, first trigger right after reset.
        set_pos(10'd10, 10'd91);
        req = 1'b1; we = 1'b0; addr = 8'h73;
        @(negedge clk); chk("rst_gnt_t", 32'(gnt0), 1);
        step();
        req = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_rvalid_hi", 32'(rvalid0), 0);
        chk("rst_gnt_hi",    32'(gnt0),    0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk_zero("post_rst");
        step();
        @(negedge clk);
        chk("post_rst_trig_en",   32'(en0),     1);
        chk("post_rst_trig_addr", 32'(maddr0),  'h03);
        chk("post_rst_rvalid",    32'(rvalid0), 0);
        step();
        @(negedge clk); chk("post_rst_rvalid2", 32'(rvalid0), 0);
        step();
        @(negedge clk);
        chk("post_rst_tile", 32'(tile0), 3);
        chk("post_rst_vld",  32'(tvld0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
